// File: rtl/llc_host_arbiter.sv
// Two-host (L1I = host 0, L1D = host 1) request arbiter in front of the LLC host port.
// An owner FIFO routes in-order read responses back to their host. Optional macro
// LLC_ARB_FIXED_PRIO_EN selects fixed priority (host 1 wins) instead of round-robin.
module llc_host_arbiter #(
  parameter int PADDR_BITS      = 19,
  parameter int B               = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_N_in,
  input  logic                  h0_valid_in,
  output logic                  h0_ready_out,
  input  logic [PADDR_BITS-1:0] h0_addr_in,
  input  logic                  h0_we_in,
  input  logic [8*B-1:0]        h0_line_in,
  output logic                  h0_valid_out,
  input  logic                  h0_ready_in,
  output logic [PADDR_BITS-1:0] h0_addr_out,
  output logic [8*B-1:0]        h0_line_out,
  input  logic                  h1_valid_in,
  output logic                  h1_ready_out,
  input  logic [PADDR_BITS-1:0] h1_addr_in,
  input  logic                  h1_we_in,
  input  logic [8*B-1:0]        h1_line_in,
  output logic                  h1_valid_out,
  input  logic                  h1_ready_in,
  output logic [PADDR_BITS-1:0] h1_addr_out,
  output logic [8*B-1:0]        h1_line_out,
  output logic                  llc_valid_out,
  input  logic                  llc_ready_in,
  output logic [PADDR_BITS-1:0] llc_addr_out,
  output logic                  llc_we_out,
  output logic [8*B-1:0]        llc_line_out,
  input  logic                  llc_valid_in,
  output logic                  llc_ready_out,
  input  logic [PADDR_BITS-1:0] llc_addr_in,
  input  logic [8*B-1:0]        llc_line_in
);

  localparam int LW = 8 * B;
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  slot_state_e           slot_state_q, slot_state_d;
  logic [PADDR_BITS-1:0] slot_addr_q, slot_addr_d;
  logic                  slot_we_q, slot_we_d;
  logic [LW-1:0]         slot_line_q, slot_line_d;

  logic                  owner_mem_q [MAX_OUTSTANDING];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  owner_full, owner_empty, owner_head;
  logic                  push, pop;

  logic [1:0]            req_valid, req_we, elig, grant, host_ready;
  logic [1:0]            rsp_ready, rsp_valid;
  logic                  slot_free, accept, winner;
  logic                  acc_we;
  logic [PADDR_BITS-1:0] acc_addr;
  logic [LW-1:0]         acc_line;

  assign req_valid = {h1_valid_in, h0_valid_in};
  assign req_we    = {h1_we_in, h0_we_in};
  assign rsp_ready = {h1_ready_in, h0_ready_in};

  assign owner_full  = (count_q == CW'(MAX_OUTSTANDING));
  assign owner_empty = (count_q == '0);
  assign owner_head  = owner_mem_q[rd_ptr_q];

  assign slot_free = (slot_state_q == SLOT_EMPTY) || llc_ready_in;

  // A read held back by a full owner FIFO is not eligible, so it cannot starve a writer.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_host
      assign elig[gi]       = req_valid[gi] && (req_we[gi] || !owner_full);
      assign host_ready[gi] = rst_N_in && slot_free && grant[gi];
      assign rsp_valid[gi]  = rst_N_in && llc_valid_in && !owner_empty &&
                              (owner_head == gi[0]);
    end
  endgenerate

`ifdef LLC_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = 2'b10;
    end
  end
`else
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = rr_ptr_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = ~winner;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  assign accept   = |host_ready;
  assign winner   = host_ready[1];
  assign acc_we   = winner ? h1_we_in   : h0_we_in;
  assign acc_addr = winner ? h1_addr_in : h0_addr_in;
  assign acc_line = winner ? h1_line_in : h0_line_in;

  assign h0_ready_out = host_ready[0];
  assign h1_ready_out = host_ready[1];

  // Request slot: a load while draining keeps it FULL for one request per cycle.
  always_comb begin
    slot_state_d = slot_state_q;
    slot_addr_d  = slot_addr_q;
    slot_we_d    = slot_we_q;
    slot_line_d  = slot_line_q;
    case (slot_state_q)
      SLOT_EMPTY: begin
        if (accept) begin
          slot_state_d = SLOT_FULL;
        end
      end
      SLOT_FULL: begin
        if (!accept && llc_ready_in) begin
          slot_state_d = SLOT_EMPTY;
        end
      end
      default: slot_state_d = SLOT_EMPTY;
    endcase
    if (accept) begin
      slot_addr_d = acc_addr;
      slot_we_d   = acc_we;
      slot_line_d = acc_line;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      slot_state_q <= SLOT_EMPTY;
      slot_addr_q  <= '0;
      slot_we_q    <= 1'b0;
      slot_line_q  <= '0;
    end else begin
      slot_state_q <= slot_state_d;
      slot_addr_q  <= slot_addr_d;
      slot_we_q    <= slot_we_d;
      slot_line_q  <= slot_line_d;
    end
  end

  assign llc_valid_out = (slot_state_q == SLOT_FULL);
  assign llc_addr_out  = slot_addr_q;
  assign llc_we_out    = slot_we_q;
  assign llc_line_out  = slot_line_q;

  // Owner FIFO: one host-id bit per outstanding read, popped by the response handshake.
  assign push = accept && !acc_we;
  assign pop  = llc_valid_in && llc_ready_out;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      owner_mem_q[wr_ptr_q] <= winner;
    end
  end

  assign llc_ready_out = rst_N_in && !owner_empty && rsp_ready[owner_head];
  assign h0_valid_out  = rsp_valid[0];
  assign h1_valid_out  = rsp_valid[1];
  assign h0_addr_out   = llc_addr_in;
  assign h1_addr_out   = llc_addr_in;
  assign h0_line_out   = llc_line_in;
  assign h1_line_out   = llc_line_in;

endmodule

// File: tb/tb_llc_host_arbiter.sv
// Self-checking bench for llc_host_arbiter: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_llc_host_arbiter;
  localparam int PB   = 19;
  localparam int LB   = 64;
  localparam int LW   = 8 * LB;
  localparam int MAXO = 4;
`ifdef LLC_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_N_in;
  logic          h0_valid_in, h0_ready_out, h0_we_in, h0_valid_out, h0_ready_in;
  logic [PB-1:0] h0_addr_in, h0_addr_out;
  logic [LW-1:0] h0_line_in, h0_line_out;
  logic          h1_valid_in, h1_ready_out, h1_we_in, h1_valid_out, h1_ready_in;
  logic [PB-1:0] h1_addr_in, h1_addr_out;
  logic [LW-1:0] h1_line_in, h1_line_out;
  logic          llc_valid_out, llc_ready_in, llc_we_out, llc_valid_in, llc_ready_out;
  logic [PB-1:0] llc_addr_out, llc_addr_in;
  logic [LW-1:0] llc_line_out, llc_line_in;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  llc_host_arbiter #(.PADDR_BITS(PB), .B(LB), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in),
    .h0_valid_in(h0_valid_in), .h0_ready_out(h0_ready_out), .h0_addr_in(h0_addr_in),
    .h0_we_in(h0_we_in), .h0_line_in(h0_line_in), .h0_valid_out(h0_valid_out),
    .h0_ready_in(h0_ready_in), .h0_addr_out(h0_addr_out), .h0_line_out(h0_line_out),
    .h1_valid_in(h1_valid_in), .h1_ready_out(h1_ready_out), .h1_addr_in(h1_addr_in),
    .h1_we_in(h1_we_in), .h1_line_in(h1_line_in), .h1_valid_out(h1_valid_out),
    .h1_ready_in(h1_ready_in), .h1_addr_out(h1_addr_out), .h1_line_out(h1_line_out),
    .llc_valid_out(llc_valid_out), .llc_ready_in(llc_ready_in), .llc_addr_out(llc_addr_out),
    .llc_we_out(llc_we_out), .llc_line_out(llc_line_out), .llc_valid_in(llc_valid_in),
    .llc_ready_out(llc_ready_out), .llc_addr_in(llc_addr_in), .llc_line_in(llc_line_in)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    h0_valid_in = 0; h0_we_in = 0; h0_addr_in = '0; h0_line_in = '0; h0_ready_in = 1;
    h1_valid_in = 0; h1_we_in = 0; h1_addr_in = '0; h1_line_in = '0; h1_ready_in = 1;
    llc_ready_in = 0; llc_valid_in = 0; llc_addr_in = '0; llc_line_in = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_N_in = 0;
    tick();
    tick();
    rst_N_in = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_N_in = 0;
    tick();
    tick();
    h0_valid_in = 1; h1_valid_in = 1; llc_valid_in = 1; llc_ready_in = 1;
    #1;
    checks++; if (h0_ready_out !== 1'b0) begin errors++; $display("FAIL rst_h0_ready got %0b exp 0", h0_ready_out); end
    checks++; if (h1_ready_out !== 1'b0) begin errors++; $display("FAIL rst_h1_ready got %0b exp 0", h1_ready_out); end
    checks++; if (llc_valid_out !== 1'b0) begin errors++; $display("FAIL rst_llc_valid got %0b exp 0", llc_valid_out); end
    checks++; if (llc_ready_out !== 1'b0) begin errors++; $display("FAIL rst_llc_ready got %0b exp 0", llc_ready_out); end
    checks++; if (h0_valid_out !== 1'b0 || h1_valid_out !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %0b%0b exp 00", h1_valid_out, h0_valid_out); end
    checks++; if (llc_addr_out !== '0 || llc_we_out !== 1'b0) begin errors++; $display("FAIL rst_slot got addr %h we %0b exp 0", llc_addr_out, llc_we_out); end
    idle();
    rst_N_in = 1;
    tick();
    checks++; if (llc_valid_out !== 1'b0) begin errors++; $display("FAIL post_rst_llc_valid got %0b exp 0", llc_valid_out); end
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    logic [LW-1:0] a5;
    a5 = {64{8'hA5}};
    do_reset();
    h1_valid_in = 1; h1_we_in = 0; h1_addr_in = 19'h00040;
    #1;
    checks++; if (h1_ready_out !== 1'b1) begin errors++; $display("FAIL single_h1_ready got %0b exp 1", h1_ready_out); end
    checks++; if (llc_valid_out !== 1'b0) begin errors++; $display("FAIL single_slot_early got %0b exp 0", llc_valid_out); end
    tick();
    h1_valid_in = 0; llc_ready_in = 1;
    #1;
    checks++; if (llc_valid_out !== 1'b1) begin errors++; $display("FAIL single_llc_valid got %0b exp 1", llc_valid_out); end
    checks++; if (llc_addr_out !== 19'h00040 || llc_we_out !== 1'b0) begin errors++; $display("FAIL single_llc_req got addr %h we %0b exp 00040 0", llc_addr_out, llc_we_out); end
    tick();
    llc_ready_in = 0; llc_valid_in = 1; llc_addr_in = 19'h00040; llc_line_in = a5;
    #1;
    checks++; if (h1_valid_out !== 1'b1 || h0_valid_out !== 1'b0) begin errors++; $display("FAIL single_route got h1 %0b h0 %0b exp 1 0", h1_valid_out, h0_valid_out); end
    checks++; if (h1_line_out !== a5 || h1_addr_out !== 19'h00040) begin errors++; $display("FAIL single_rsp_data got addr %h line %h", h1_addr_out, h1_line_out); end
    checks++; if (llc_ready_out !== 1'b1) begin errors++; $display("FAIL single_llc_ready got %0b exp 1", llc_ready_out); end
    tick();
    idle();
    $display("test_single_read done");
  endtask

  task automatic test_contention();
    int prev;
    int exp_w;
    logic [PB-1:0] exp_a;
    do_reset();
    llc_ready_in = 1;
    h0_valid_in = 1; h0_we_in = 1; h0_addr_in = 19'h01000;
    h1_valid_in = 1; h1_we_in = 1; h1_addr_in = 19'h02000;
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_w = FIXED ? 1 : (i % 2);
      checks++; if (h0_ready_out !== (exp_w == 0) || h1_ready_out !== (exp_w == 1)) begin errors++; $display("FAIL contention_grant cyc %0d got %0b%0b exp host %0d", i, h1_ready_out, h0_ready_out, exp_w); end
      if (prev >= 0) begin
        exp_a = (prev == 0) ? 19'h01000 : 19'h02000;
        checks++; if (llc_addr_out !== exp_a) begin errors++; $display("FAIL contention_addr cyc %0d got %h exp %h", i, llc_addr_out, exp_a); end
      end
      prev = exp_w;
      tick();
    end
    idle();
    $display("test_contention done");
  endtask

  task automatic test_owner_full();
    do_reset();
    llc_ready_in = 1;
    h0_valid_in = 1; h0_we_in = 0;
    for (int i = 0; i < MAXO; i++) begin
      h0_addr_in = PB'(32'h10 + i);
      #1;
      checks++; if (h0_ready_out !== 1'b1) begin errors++; $display("FAIL full_fill_ready %0d got %0b exp 1", i, h0_ready_out); end
      tick();
    end
    h0_addr_in = 19'h00014;
    h1_valid_in = 1; h1_we_in = 1; h1_addr_in = 19'h7FFFF;
    #1;
    checks++; if (h0_ready_out !== 1'b0) begin errors++; $display("FAIL full_blocked_read got %0b exp 0", h0_ready_out); end
    checks++; if (h1_ready_out !== 1'b1) begin errors++; $display("FAIL full_write_pass got %0b exp 1", h1_ready_out); end
    tick();
    h1_valid_in = 0;
    #1;
    checks++; if (h0_ready_out !== 1'b0) begin errors++; $display("FAIL full_still_blocked got %0b exp 0", h0_ready_out); end
    checks++; if (llc_addr_out !== 19'h7FFFF || llc_we_out !== 1'b1) begin errors++; $display("FAIL full_write_slot got %h %0b exp 7ffff 1", llc_addr_out, llc_we_out); end
    llc_valid_in = 1; llc_addr_in = 19'h00010;
    #1;
    checks++; if (h0_valid_out !== 1'b1 || llc_ready_out !== 1'b1) begin errors++; $display("FAIL full_rsp got v %0b r %0b exp 1 1", h0_valid_out, llc_ready_out); end
    checks++; if (h0_ready_out !== 1'b0) begin errors++; $display("FAIL full_same_cycle_pop got %0b exp 0", h0_ready_out); end
    tick();
    llc_valid_in = 0;
    #1;
    checks++; if (h0_ready_out !== 1'b1) begin errors++; $display("FAIL full_after_pop got %0b exp 1", h0_ready_out); end
    tick();
    h0_valid_in = 0;
    #1;
    checks++; if (llc_addr_out !== 19'h00014 || llc_we_out !== 1'b0) begin errors++; $display("FAIL full_fifth_slot got %h %0b exp 00014 0", llc_addr_out, llc_we_out); end
    idle();
    $display("test_owner_full done");
  endtask

  task automatic test_backpressure();
    logic [LW-1:0] la, lb;
    la = {16{32'hDEADBEEF}};
    lb = {16{32'h12345678}};
    do_reset();
    h0_valid_in = 1; h0_we_in = 1; h0_addr_in = 19'h00123; h0_line_in = la;
    #1;
    checks++; if (h0_ready_out !== 1'b1) begin errors++; $display("FAIL bp_first_ready got %0b exp 1", h0_ready_out); end
    tick();
    h0_addr_in = 19'h00456; h0_line_in = lb;
    h1_valid_in = 1; h1_we_in = 0; h1_addr_in = 19'h000AA;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (llc_valid_out !== 1'b1 || llc_addr_out !== 19'h00123 || llc_we_out !== 1'b1) begin errors++; $display("FAIL bp_slot_stable cyc %0d got v %0b addr %h we %0b", i, llc_valid_out, llc_addr_out, llc_we_out); end
      checks++; if (llc_line_out !== la) begin errors++; $display("FAIL bp_line_stable cyc %0d got %h", i, llc_line_out); end
      checks++; if (h0_ready_out !== 1'b0 || h1_ready_out !== 1'b0) begin errors++; $display("FAIL bp_ready cyc %0d got %0b%0b exp 00", i, h1_ready_out, h0_ready_out); end
      tick();
    end
    llc_ready_in = 1;
    #1;
    checks++; if (h1_ready_out !== 1'b1 || h0_ready_out !== 1'b0) begin errors++; $display("FAIL bp_release_grant got %0b%0b exp 10", h1_ready_out, h0_ready_out); end
    tick();
    h1_valid_in = 0; h0_valid_in = 0;
    #1;
    checks++; if (llc_addr_out !== 19'h000AA || llc_we_out !== 1'b0 || llc_valid_out !== 1'b1) begin errors++; $display("FAIL bp_reload got %h %0b v %0b exp 000aa 0 1", llc_addr_out, llc_we_out, llc_valid_out); end
    idle();
    $display("test_backpressure done");
  endtask

  task automatic test_response_order();
    do_reset();
    llc_ready_in = 1;
    h0_valid_in = 1; h0_addr_in = 19'h00010; tick();
    h0_valid_in = 0; h1_valid_in = 1; h1_addr_in = 19'h00020; tick();
    h1_valid_in = 0; h0_valid_in = 1; h0_addr_in = 19'h00030; tick();
    h0_valid_in = 0; h1_ready_in = 0;
    llc_valid_in = 1; llc_addr_in = 19'h00010;
    #1;
    checks++; if (h0_valid_out !== 1'b1 || h1_valid_out !== 1'b0 || h0_addr_out !== 19'h00010) begin errors++; $display("FAIL order_rsp0 got v %0b%0b addr %h", h1_valid_out, h0_valid_out, h0_addr_out); end
    checks++; if (llc_ready_out !== 1'b1) begin errors++; $display("FAIL order_rsp0_ready got %0b exp 1", llc_ready_out); end
    tick();
    llc_addr_in = 19'h00020;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (h1_valid_out !== 1'b1 || h0_valid_out !== 1'b0) begin errors++; $display("FAIL order_rsp1_route cyc %0d got %0b%0b exp 10", i, h1_valid_out, h0_valid_out); end
      checks++; if (llc_ready_out !== 1'b0) begin errors++; $display("FAIL order_rsp1_stall cyc %0d got %0b exp 0", i, llc_ready_out); end
      tick();
    end
    h1_ready_in = 1;
    #1;
    checks++; if (llc_ready_out !== 1'b1 || h1_addr_out !== 19'h00020) begin errors++; $display("FAIL order_rsp1 got r %0b addr %h", llc_ready_out, h1_addr_out); end
    tick();
    llc_addr_in = 19'h00030;
    #1;
    checks++; if (h0_valid_out !== 1'b1 || h1_valid_out !== 1'b0 || h0_addr_out !== 19'h00030) begin errors++; $display("FAIL order_rsp2 got v %0b%0b addr %h", h1_valid_out, h0_valid_out, h0_addr_out); end
    tick();
    idle();
    #1;
    checks++; if (llc_ready_out !== 1'b0) begin errors++; $display("FAIL order_drained got %0b exp 0", llc_ready_out); end
    $display("test_response_order done");
  endtask

  task automatic test_mid_reset();
    do_reset();
    llc_ready_in = 1;
    h0_valid_in = 1; h0_addr_in = 19'h00001; tick();
    h0_addr_in = 19'h00002; tick();
    idle();
    rst_N_in = 0;
    tick();
    rst_N_in = 1;
    #1;
    checks++; if (llc_valid_out !== 1'b0 || llc_addr_out !== '0 || llc_we_out !== 1'b0) begin errors++; $display("FAIL midrst_slot got v %0b addr %h we %0b", llc_valid_out, llc_addr_out, llc_we_out); end
    checks++; if (h0_ready_out !== 1'b0 || h1_ready_out !== 1'b0 || h0_valid_out !== 1'b0 || h1_valid_out !== 1'b0) begin errors++; $display("FAIL midrst_host got %0b%0b%0b%0b", h0_ready_out, h1_ready_out, h0_valid_out, h1_valid_out); end
    llc_valid_in = 1; llc_addr_in = 19'h00001;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (llc_ready_out !== 1'b0 || h0_valid_out !== 1'b0 || h1_valid_out !== 1'b0) begin errors++; $display("FAIL midrst_orphan_rsp cyc %0d got r %0b v %0b%0b", i, llc_ready_out, h1_valid_out, h0_valid_out); end
      tick();
    end
    llc_valid_in = 0;
    h0_valid_in = 1; h0_we_in = 0; h0_addr_in = 19'h00055;
    #1;
    checks++; if (h0_ready_out !== 1'b1) begin errors++; $display("FAIL midrst_fresh_ready got %0b exp 1", h0_ready_out); end
    tick();
    h0_valid_in = 0; llc_ready_in = 1;
    #1;
    checks++; if (llc_valid_out !== 1'b1 || llc_addr_out !== 19'h00055) begin errors++; $display("FAIL midrst_fresh_req got v %0b addr %h", llc_valid_out, llc_addr_out); end
    tick();
    llc_valid_in = 1; llc_addr_in = 19'h00055;
    #1;
    checks++; if (h0_valid_out !== 1'b1 || llc_ready_out !== 1'b1) begin errors++; $display("FAIL midrst_fresh_rsp got v %0b r %0b", h0_valid_out, llc_ready_out); end
    tick();
    idle();
    $display("test_mid_reset done");
  endtask

  task automatic test_random();
    logic          m_valid, m_we;
    logic [PB-1:0] m_addr;
    logic [LW-1:0] m_line;
    int            owners[$];
    int            pref, win, head;
    bit            full, free, e0, e1, nonempty;
    logic          exp_r0, exp_r1, exp_v0, exp_v1, exp_lr;
    int            n_acc, n_rsp;
    do_reset();
    m_valid = 0; m_we = 0; m_addr = '0; m_line = '0;
    pref = 0; n_acc = 0; n_rsp = 0;
    owners.delete();
    for (int c = 0; c < 500; c++) begin
      h0_valid_in = 1'($urandom_range(0, 1));
      h0_we_in    = ($urandom_range(0, 3) == 0);
      h0_addr_in  = PB'($urandom);
      h0_line_in  = {16{$urandom}};
      h1_valid_in = 1'($urandom_range(0, 1));
      h1_we_in    = ($urandom_range(0, 3) == 0);
      h1_addr_in  = PB'($urandom);
      h1_line_in  = {16{$urandom}};
      h0_ready_in = ($urandom_range(0, 3) != 0);
      h1_ready_in = ($urandom_range(0, 3) != 0);
      llc_ready_in = ($urandom_range(0, 3) != 0);
      nonempty = (owners.size() > 0);
      llc_valid_in = nonempty && ($urandom_range(0, 1) == 1);
      llc_addr_in = PB'($urandom);
      llc_line_in = {16{$urandom}};
      #1;
      full = (owners.size() >= MAXO);
      e0 = h0_valid_in && (h0_we_in || !full);
      e1 = h1_valid_in && (h1_we_in || !full);
      free = !m_valid || llc_ready_in;
      if (e0 && e1) win = FIXED ? 1 : pref;
      else if (e0) win = 0;
      else if (e1) win = 1;
      else win = -1;
      exp_r0 = free && (win == 0);
      exp_r1 = free && (win == 1);
      head = nonempty ? owners[0] : -1;
      exp_v0 = llc_valid_in && (head == 0);
      exp_v1 = llc_valid_in && (head == 1);
      exp_lr = (head == 0) ? h0_ready_in : ((head == 1) ? h1_ready_in : 1'b0);
      checks++; if (h0_ready_out !== exp_r0 || h1_ready_out !== exp_r1) begin errors++; $display("FAIL rand_ready cyc %0d got %0b%0b exp %0b%0b", c, h1_ready_out, h0_ready_out, exp_r1, exp_r0); end
      checks++; if (llc_valid_out !== m_valid) begin errors++; $display("FAIL rand_llc_valid cyc %0d got %0b exp %0b", c, llc_valid_out, m_valid); end
      if (m_valid) begin
        checks++; if (llc_addr_out !== m_addr || llc_we_out !== m_we || llc_line_out !== m_line) begin errors++; $display("FAIL rand_slot cyc %0d got addr %h we %0b exp addr %h we %0b", c, llc_addr_out, llc_we_out, m_addr, m_we); end
      end
      checks++; if (h0_valid_out !== exp_v0 || h1_valid_out !== exp_v1) begin errors++; $display("FAIL rand_rsp_valid cyc %0d got %0b%0b exp %0b%0b", c, h1_valid_out, h0_valid_out, exp_v1, exp_v0); end
      checks++; if (llc_ready_out !== exp_lr) begin errors++; $display("FAIL rand_llc_ready cyc %0d got %0b exp %0b", c, llc_ready_out, exp_lr); end
      if (exp_v0) begin
        checks++; if (h0_addr_out !== llc_addr_in || h0_line_out !== llc_line_in) begin errors++; $display("FAIL rand_rsp0_data cyc %0d got addr %h exp %h", c, h0_addr_out, llc_addr_in); end
      end
      if (exp_v1) begin
        checks++; if (h1_addr_out !== llc_addr_in || h1_line_out !== llc_line_in) begin errors++; $display("FAIL rand_rsp1_data cyc %0d got addr %h exp %h", c, h1_addr_out, llc_addr_in); end
      end
      if (llc_valid_in && exp_lr) begin
        void'(owners.pop_front());
        n_rsp++;
      end
      if (m_valid && llc_ready_in) m_valid = 0;
      if (win >= 0 && free) begin
        m_valid = 1;
        m_we    = (win == 1) ? h1_we_in   : h0_we_in;
        m_addr  = (win == 1) ? h1_addr_in : h0_addr_in;
        m_line  = (win == 1) ? h1_line_in : h0_line_in;
        if (!m_we) owners.push_back(win);
        pref = 1 - win;
        n_acc++;
      end
      tick();
    end
    idle();
    $display("test_random done accepted %0d responses %0d", n_acc, n_rsp);
  endtask

  initial begin
    rst_N_in = 0;
    idle();
    test_reset();
    test_single_read();
    test_contention();
    test_owner_full();
    test_backpressure();
    test_response_order();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
